dcache_direct_wb: RTL and testbench

- Direct-mapped, write-back, write-allocate data cache between the single-cycle RV64 core's data port and the slow 128-bit line memory.
- Hits return in the same cycle with no stall. Misses stall the core while the cache runs a memory handshake that waits on mem_ready.
- Data passes through untouched. The core's nibble-order conversion stays outside this block.

---
 rtl/dcache_direct_wb_if.sv | 28 ++
 rtl/dcache_direct_wb.sv | 146 ++++++++++++++
 tb/tb_dcache_direct_wb.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/dcache_direct_wb_if.sv
// Core-side and memory-side signal bundle for dcache_direct_wb.
//   slave  : the cache's view (core requests and memory responses in, results and
//            memory requests out)
//   master : the environment's view (core + line memory), directions mirrored
interface dcache_direct_wb_if;
  logic         proc_read;
  logic         proc_write;
  logic [31:0]  proc_addr;
  logic [63:0]  proc_wdata;
  logic [63:0]  proc_rdata;
  logic         proc_stall;
  logic         mem_read;
  logic         mem_write;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata;
  logic         mem_ready;

  modport slave (
    input  proc_read, proc_write, proc_addr, proc_wdata, mem_rdata, mem_ready,
    output proc_rdata, proc_stall, mem_read, mem_write, mem_addr, mem_wdata
  );

  modport master (
    output proc_read, proc_write, proc_addr, proc_wdata, mem_rdata, mem_ready,
    input  proc_rdata, proc_stall, mem_read, mem_write, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dcache_direct_wb.sv
// Direct-mapped, write-back, write-allocate data cache between the core data
// port and a 128-bit line memory. Hits complete combinationally with no stall;
// misses stall the core while a writeback (dirty victim) and/or a line fill run.
// Ports:
//   clk    : system clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : dcache_direct_wb_if.slave (core request/response, memory handshake)
//
// state     | meaning
// IDLE      | serve hits; on a miss launch writeback or fill
// WRITEBACK | mem_write held with the victim line until mem_ready
// ALLOCATE  | mem_read held for the requested line until mem_ready
module dcache_direct_wb #(
  parameter int NUM_LINES = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  dcache_direct_wb_if.slave bus
);
  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = 28 - IDX_W;

  typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE} state_t;

  state_t               r_state, w_state_nxt;
  logic [NUM_LINES-1:0] r_valid, r_dirty;
  logic [TAG_W-1:0]     r_tag  [NUM_LINES];
  logic [127:0]         r_data [NUM_LINES];

  logic         r_mem_read, r_mem_write;
  logic [27:0]  r_mem_addr;
  logic [127:0] r_mem_wdata;
  logic         w_mem_read_nxt, w_mem_write_nxt;
  logic [27:0]  w_mem_addr_nxt;
  logic [127:0] w_mem_wdata_nxt;

  logic [IDX_W-1:0] w_idx;
  logic [TAG_W-1:0] w_tag;
  logic             w_word, w_req, w_hit;
  logic             w_fill, w_wb_done, w_store_hit, w_stall;
  logic [127:0]     w_line;

  assign w_idx  = bus.proc_addr[3+IDX_W:4];
  assign w_tag  = bus.proc_addr[31:4+IDX_W];
  assign w_word = bus.proc_addr[3];
  assign w_req  = bus.proc_read | bus.proc_write;
  assign w_line = r_data[w_idx];
  assign w_hit  = w_req & r_valid[w_idx] & (r_tag[w_idx] == w_tag);

  always_comb begin
    w_state_nxt     = r_state;
    w_mem_read_nxt  = r_mem_read;
    w_mem_write_nxt = r_mem_write;
    w_mem_addr_nxt  = r_mem_addr;
    w_mem_wdata_nxt = r_mem_wdata;
    w_fill          = 1'b0;
    w_wb_done       = 1'b0;
    w_store_hit     = 1'b0;
    w_stall         = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_req) begin
          if (w_hit) begin
            // Read+write together is a write.
            w_store_hit = bus.proc_write;
          end else begin
            w_stall = 1'b1;
            if (r_valid[w_idx] && r_dirty[w_idx]) begin
              w_state_nxt     = WRITEBACK;
              w_mem_write_nxt = 1'b1;
              w_mem_addr_nxt  = {r_tag[w_idx], w_idx};
              w_mem_wdata_nxt = w_line;
            end else begin
              w_state_nxt    = ALLOCATE;
              w_mem_read_nxt = 1'b1;
              w_mem_addr_nxt = bus.proc_addr[31:4];
            end
          end
        end
      end
      WRITEBACK: begin
        w_stall = 1'b1;
        if (bus.mem_ready) begin
          w_wb_done       = 1'b1;
          w_state_nxt     = ALLOCATE;
          w_mem_write_nxt = 1'b0;
          w_mem_read_nxt  = 1'b1;
          w_mem_addr_nxt  = bus.proc_addr[31:4];
        end
      end
      ALLOCATE: begin
        w_stall = 1'b1;
        if (bus.mem_ready) begin
          w_fill         = 1'b1;
          w_state_nxt    = IDLE;
          w_mem_read_nxt = 1'b0;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_valid     <= '0;
      r_dirty     <= '0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_mem_read  <= w_mem_read_nxt;
      r_mem_write <= w_mem_write_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_mem_wdata <= w_mem_wdata_nxt;
      if (w_fill) begin
        r_valid[w_idx] <= 1'b1;
        r_dirty[w_idx] <= 1'b0;
      end
      if (w_wb_done) r_dirty[w_idx] <= 1'b0;
      if (w_store_hit) r_dirty[w_idx] <= 1'b1;
    end
  end

  // Tag and data arrays carry no reset; valid bits qualify them.
  always_ff @(posedge clk) begin
    if (w_fill) begin
      r_data[w_idx] <= bus.mem_rdata;
      r_tag[w_idx]  <= w_tag;
    end else if (w_store_hit) begin
      if (w_word) r_data[w_idx][127:64] <= bus.proc_wdata;
      else        r_data[w_idx][63:0]   <= bus.proc_wdata;
    end
  end

  // Stall is forced low during reset so the core sees an idle cache.
  assign bus.proc_stall = rst_n & w_stall;
  assign bus.proc_rdata = (r_state == IDLE && w_hit) ?
                          (w_word ? w_line[127:64] : w_line[63:0]) : 64'd0;
  assign bus.mem_read   = r_mem_read;
  assign bus.mem_write  = r_mem_write;
  assign bus.mem_addr   = r_mem_addr;
  assign bus.mem_wdata  = r_mem_wdata;
endmodule

// File: tb/tb_dcache_direct_wb.sv
module tb_dcache_direct_wb;
  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  dcache_direct_wb_if bus ();

  dcache_direct_wb #(.NUM_LINES(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic req(input logic rd, input logic wr, input logic [31:0] addr,
                     input logic [63:0] wd);
    bus.proc_read  = rd;
    bus.proc_write = wr;
    bus.proc_addr  = addr;
    bus.proc_wdata = wd;
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus.proc_read  = 1'b0;
    bus.proc_write = 1'b0;
    bus.proc_addr  = 32'd0;
    bus.proc_wdata = 64'd0;
    bus.mem_rdata  = 128'd0;
    bus.mem_ready  = 1'b0;
    #3;
    check("rst_mem_read",  bus.mem_read,   0);
    check("rst_mem_write", bus.mem_write,  0);
    check("rst_mem_addr",  bus.mem_addr,   0);
    check("rst_mem_wdata", bus.mem_wdata,  0);
    check("rst_stall",     bus.proc_stall, 0);
    check("rst_rdata",     bus.proc_rdata, 0);
    #9 rst_n = 1'b1;
    cyc();

    // Cold read miss, clean victim
    req(1, 0, 32'h0001_0008, 0);
    check("cold_stall", bus.proc_stall, 1);
    check("cold_no_req_yet", bus.mem_read, 0);
    cyc();
    check("cold_mem_read", bus.mem_read, 1);
    check("cold_mem_addr", bus.mem_addr, 28'h0001000);
    check("cold_mem_write", bus.mem_write, 0);
    cyc();
    cyc();
    check("cold_wait_stall", bus.proc_stall, 1);
    bus.mem_rdata = {64'hBBBB, 64'hAAAA};
    bus.mem_ready = 1'b1;
    cyc();
    bus.mem_ready = 1'b0;
    #1;
    check("cold_read_drop", bus.mem_read, 0);
    check("cold_done_stall", bus.proc_stall, 0);
    check("cold_rdata", bus.proc_rdata, 64'hBBBB);
    cyc();

    // Hit on the other word of the filled line
    req(1, 0, 32'h0001_0000, 0);
    check("hit_stall", bus.proc_stall, 0);
    check("hit_rdata", bus.proc_rdata, 64'hAAAA);
    cyc();
    check("hit_mem_read", bus.mem_read, 0);
    check("hit_mem_write", bus.mem_write, 0);

    // Write hit, then a conflicting read forces a dirty writeback
    req(0, 1, 32'h0001_0000, 64'h1234);
    check("wrhit_stall", bus.proc_stall, 0);
    cyc();
    req(1, 0, 32'h0001_0080, 0);
    check("conf_stall", bus.proc_stall, 1);
    cyc();
    check("wb_mem_write", bus.mem_write, 1);
    check("wb_mem_read", bus.mem_read, 0);
    check("wb_mem_addr", bus.mem_addr, 28'h0001000);
    check("wb_mem_wdata", bus.mem_wdata, {64'hBBBB, 64'h1234});
    cyc();
    check("wb_hold_write", bus.mem_write, 1);
    check("wb_hold_stall", bus.proc_stall, 1);
    bus.mem_ready = 1'b1;
    cyc();
    bus.mem_ready = 1'b0;
    #1;
    check("wb2al_mem_write", bus.mem_write, 0);
    check("wb2al_mem_read", bus.mem_read, 1);
    check("wb2al_mem_addr", bus.mem_addr, 28'h0001008);

    // Long memory latency: everything held for 20 cycles
    for (int i = 0; i < 20; i++) begin
      cyc();
      check("slow_stall", bus.proc_stall, 1);
      check("slow_mem_read", bus.mem_read, 1);
      check("slow_mem_addr", bus.mem_addr, 28'h0001008);
    end
    bus.mem_rdata = {64'hD1, 64'hD0};
    bus.mem_ready = 1'b1;
    cyc();
    bus.mem_ready = 1'b0;
    #1;
    check("conf_done_stall", bus.proc_stall, 0);
    check("conf_rdata", bus.proc_rdata, 64'hD0);
    cyc();

    // Write miss allocates, then merges the store
    req(0, 1, 32'h0002_0010, 64'h5555);
    check("wmiss_stall", bus.proc_stall, 1);
    cyc();
    check("wmiss_mem_read", bus.mem_read, 1);
    check("wmiss_mem_addr", bus.mem_addr, 28'h0002001);
    bus.mem_rdata = 128'd0;
    bus.mem_ready = 1'b1;
    cyc();
    bus.mem_ready = 1'b0;
    #1;
    check("wmiss_retry_stall", bus.proc_stall, 0);
    cyc();
    req(1, 0, 32'h0002_0010, 0);
    check("wmiss_rd_stall", bus.proc_stall, 0);
    check("wmiss_rd_data", bus.proc_rdata, 64'h5555);
    cyc();

    // Stray mem_ready while idle is ignored
    req(0, 0, 32'h0, 0);
    bus.mem_ready = 1'b1;
    cyc();
    bus.mem_ready = 1'b0;
    check("stray_mem_read", bus.mem_read, 0);
    check("stray_mem_write", bus.mem_write, 0);

    // Evicting the merged line writes it back
    req(1, 0, 32'h0002_0090, 0);
    cyc();
    check("evict_mem_write", bus.mem_write, 1);
    check("evict_mem_addr", bus.mem_addr, 28'h0002001);
    check("evict_mem_wdata", bus.mem_wdata, {64'h0, 64'h5555});

    // Reset while in WRITEBACK
    #2;
    rst_n = 1'b0;
    #1;
    check("rstwb_mem_write", bus.mem_write, 0);
    check("rstwb_stall", bus.proc_stall, 0);
    req(0, 0, 32'h0, 0);
    cyc();
    rst_n = 1'b1;
    #1;
    check("after_rst_stall", bus.proc_stall, 0);
    cyc();
    req(1, 0, 32'h0001_0080, 0);
    check("after_rst_miss", bus.proc_stall, 1);
    cyc();
    check("after_rst_mem_read", bus.mem_read, 1);
    check("after_rst_mem_write", bus.mem_write, 0);
    check("after_rst_mem_addr", bus.mem_addr, 28'h0001008);
    req(0, 0, 32'h0, 0);
    rst_n = 1'b0;
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
